conv_window_mac: RTL

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_window_mac_pkg.sv | 21 ++
 rtl/window_adder_tree.sv | 31 +++
 rtl/conv_window_mac.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/conv_window_mac_pkg.sv
// Shared definitions for the 3x3 convolution window MAC: FSM encoding, datapath
// widths and the byte-lane mapping used to unpack window rows.
package conv_window_mac_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int NUM_TAPS = 9;
    localparam int PROD_W   = 17;  // u8 * s8 product, signed
    localparam int SUM_W    = 21;  // nine products summed, signed
    localparam int STAGES   = 3;   // register stages after the input capture

    // Column 0 sits in the most significant element of a row word.
    function automatic int lane_lsb(input int col, input int elem_w);
        return elem_w * (2 - col);
    endfunction

endpackage

// File: rtl/window_adder_tree.sv
// Combinational balanced adder tree summing the nine signed window products.
module window_adder_tree
    import conv_window_mac_pkg::*;
#(
    parameter int IN_W  = PROD_W,
    parameter int OUT_W = SUM_W
) (
    input  logic [NUM_TAPS-1:0][IN_W-1:0] terms_i,
    output logic [OUT_W-1:0]              sum_o
);

    logic [NUM_TAPS-1:0][OUT_W-1:0] ext;
    logic [3:0][OUT_W-1:0]          lvl1;
    logic [1:0][OUT_W-1:0]          lvl2;
    logic [OUT_W-1:0]               lvl3;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_ext
        assign ext[i] = {{(OUT_W-IN_W){terms_i[i][IN_W-1]}}, terms_i[i]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        assign lvl1[i] = ext[2*i] + ext[2*i+1];
    end

    assign lvl2[0] = lvl1[0] + lvl1[1];
    assign lvl2[1] = lvl1[2] + lvl1[3];
    assign lvl3    = lvl2[0] + lvl2[1];
    // The odd ninth tap joins at the root so the tree stays balanced.
    assign sum_o   = lvl3 + ext[NUM_TAPS-1];

endmodule

// File: rtl/conv_window_mac.sv
// 3x3 window multiply-accumulate: 4-stage pipeline feeding an accumulator that
// sums `channel` windows per result. Define CONV_WINDOW_MAC_RELU_EN to clamp
// negative results to zero.
module conv_window_mac
    import conv_window_mac_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [11:0]               channel,
    input  logic                      act_valid,
    input  logic [3*WEIGHT_WIDTH-1:0] activate0,
    input  logic [3*WEIGHT_WIDTH-1:0] activate1,
    input  logic [3*WEIGHT_WIDTH-1:0] activate2,
    input  logic [3*WEIGHT_WIDTH-1:0] weight0,
    input  logic [3*WEIGHT_WIDTH-1:0] weight1,
    input  logic [3*WEIGHT_WIDTH-1:0] weight2,
    output logic                      act_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic                      err_drop
);

    state_e state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] chan_q, chan_d;
    logic [11:0] chan_eff, target;
    logic        accept, win_last, acc_clr, load_out;

    logic [STAGES:0] vld_pipe_q;
    logic [STAGES:0] last_pipe_q;

    logic [2:0][3*WEIGHT_WIDTH-1:0]           act_rows, wgt_rows;
    logic [NUM_TAPS-1:0][WEIGHT_WIDTH-1:0]    act_tap, wgt_tap;
    logic [NUM_TAPS-1:0][WEIGHT_WIDTH-1:0]    act_s1_q, wgt_s1_q;
    logic [NUM_TAPS-1:0][PROD_W-1:0]          prod_d, prod_q;
    logic [SUM_W-1:0]                         sum_d, sum_q;
    logic [ACC_WIDTH-1:0]                     acc_q, result;
    logic [ACC_WIDTH-1:0]                     out_data_q;
    logic                                     err_drop_q;

    // ---------------------------------------------------------------- control
    assign act_ready = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = act_valid && act_ready;
    assign chan_eff  = (channel == 12'd0) ? 12'd1 : channel;
    // channel is only honoured on the first window of a result.
    assign target    = (cnt_q == 12'd0) ? chan_eff : chan_q;
    assign win_last  = accept && (12'(cnt_q + 12'd1) == target);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        acc_clr  = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == 12'd0) chan_d = chan_eff;
                    if (win_last) begin
                        cnt_d   = 12'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = 12'(cnt_q + 12'd1);
                    end
                end
            end
            ST_DRAIN: begin
                if (vld_pipe_q[STAGES] && last_pipe_q[STAGES]) begin
                    state_d  = ST_HOLD;
                    load_out = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    acc_clr = 1'b1;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            chan_q      <= 12'd1;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], accept};
            last_pipe_q <= {last_pipe_q[STAGES-1:0], win_last};
            if (act_valid && !act_ready) err_drop_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath
    assign act_rows = {activate2, activate1, activate0};
    assign wgt_rows = {weight2, weight1, weight0};

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign act_tap[3*r+c] = act_rows[r][lane_lsb(c, WEIGHT_WIDTH) +: WEIGHT_WIDTH];
            assign wgt_tap[3*r+c] = wgt_rows[r][lane_lsb(c, WEIGHT_WIDTH) +: WEIGHT_WIDTH];
        end
    end

    // Activations are unsigned pixels, weights signed: extend accordingly.
    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_mul
        assign prod_d[t] =
            $signed({{(PROD_W-WEIGHT_WIDTH){1'b0}}, act_s1_q[t]}) *
            $signed({{(PROD_W-WEIGHT_WIDTH){wgt_s1_q[t][WEIGHT_WIDTH-1]}}, wgt_s1_q[t]});
    end

    window_adder_tree #(
        .IN_W  (PROD_W),
        .OUT_W (SUM_W)
    ) u_tree (
        .terms_i (prod_q),
        .sum_o   (sum_d)
    );

`ifdef CONV_WINDOW_MAC_RELU_EN
    assign result = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
`else
    assign result = acc_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_s1_q   <= '0;
            wgt_s1_q   <= '0;
            prod_q     <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            if (accept) begin
                act_s1_q <= act_tap;
                wgt_s1_q <= wgt_tap;
            end
            if (vld_pipe_q[0]) prod_q <= prod_d;
            if (vld_pipe_q[1]) sum_q  <= sum_d;
            if (acc_clr)
                acc_q <= '0;
            else if (vld_pipe_q[2])
                acc_q <= acc_q + {{(ACC_WIDTH-SUM_W){sum_q[SUM_W-1]}}, sum_q};
            if (load_out) out_data_q <= result;
        end
    end

    assign out_data = out_data_q;
    assign err_drop = err_drop_q;

endmodule
